// File: rtl/systolic_tile_sequencer.sv
// Command sequencer for the systolic matmul array: walks an M x N grid of output
// tiles per command, issuing stream requests and an array start for each tile.
module systolic_tile_sequencer #(
    parameter int SYSTOLIC_ARRAY_DIM = 8,
    parameter int DATA_WIDTH_BITS    = 16,
    parameter int TILE_CNT_BITS      = 8
) (
    input  logic                       clock,
    input  logic                       areset,
    input  logic                       cmd_matmul_valid,
    output logic                       cmd_matmul_ready,
    input  logic [19:0]                cmd_matmul_inner_dimension,
    input  logic [TILE_CNT_BITS-1:0]   cmd_matmul_m_tiles,
    input  logic [TILE_CNT_BITS-1:0]   cmd_matmul_n_tiles,
    input  logic [63:0]                cmd_matmul_out_addr,
    input  logic [63:0]                cmd_matmul_act_addr,
    input  logic [63:0]                cmd_matmul_wgt_addr,
    output logic                       resp_matmul_valid,
    input  logic                       resp_matmul_ready,
    output logic [2*TILE_CNT_BITS-1:0] resp_matmul_tiles_done,
    output logic                       weights_req_valid,
    input  logic                       weights_req_ready,
    output logic [33:0]                weights_req_len,
    output logic [63:0]                weights_req_addr_address,
    output logic                       activations_req_valid,
    input  logic                       activations_req_ready,
    output logic [33:0]                activations_req_len,
    output logic [63:0]                activations_req_addr_address,
    output logic                       vec_out_req_valid,
    input  logic                       vec_out_req_ready,
    output logic [33:0]                vec_out_req_len,
    output logic [63:0]                vec_out_req_addr_address,
    input  logic                       weights_inProgress,
    input  logic                       activations_inProgress,
    input  logic                       vec_out_isFlushed,
    output logic                       sa_start_valid,
    input  logic                       sa_start_ready,
    output logic [19:0]                sa_inner_dimension,
    output logic                       busy
);

    localparam int          BYTES     = DATA_WIDTH_BITS / 8;
    localparam int          D         = SYSTOLIC_ARRAY_DIM;
    localparam logic [33:0] ROW_BYTES = 34'(D * BYTES);
    localparam logic [33:0] OUT_LEN   = 34'(D * D * BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_START, S_WAIT, S_NEXT, S_RESP
    } state_t;

    state_t r_state, w_next;

    logic [19:0]                r_k;
    logic [TILE_CNT_BITS-1:0]   r_m, r_n, r_i, r_j;
    logic [63:0]                r_act_cur, r_wgt_cur, r_out_cur, r_wgt_base;
    logic [2*TILE_CNT_BITS-1:0] r_tiles_done;
    logic                       r_w_sent, r_a_sent, r_o_sent, r_seen_busy;

    logic [33:0] w_in_len;
    logic        w_w_fire, w_a_fire, w_o_fire, w_all_sent;
    logic        w_cmd_empty, w_last_col, w_last_row, w_tile_done;

    assign w_in_len    = 34'(r_k) * ROW_BYTES;
    assign w_w_fire    = weights_req_valid && weights_req_ready;
    assign w_a_fire    = activations_req_valid && activations_req_ready;
    assign w_o_fire    = vec_out_req_valid && vec_out_req_ready;
    assign w_all_sent  = (r_w_sent || w_w_fire) && (r_a_sent || w_a_fire) && (r_o_sent || w_o_fire);
    assign w_cmd_empty = (cmd_matmul_inner_dimension == '0) || (cmd_matmul_m_tiles == '0)
                         || (cmd_matmul_n_tiles == '0);
    assign w_last_col  = ({1'b0, r_j} + 1'b1) >= {1'b0, r_n};
    assign w_last_row  = ({1'b0, r_i} + 1'b1) >= {1'b0, r_m};
    // The array must have been seen busy before idle counts as completion.
    assign w_tile_done = r_seen_busy && sa_start_ready && vec_out_isFlushed
                         && !weights_inProgress && !activations_inProgress;

    assign weights_req_len              = w_in_len;
    assign activations_req_len          = w_in_len;
    assign vec_out_req_len              = OUT_LEN;
    assign weights_req_addr_address     = r_wgt_cur;
    assign activations_req_addr_address = r_act_cur;
    assign vec_out_req_addr_address     = r_out_cur;
    assign sa_inner_dimension           = r_k;
    assign resp_matmul_tiles_done       = r_tiles_done;

    always_comb begin
        w_next                = r_state;
        cmd_matmul_ready      = 1'b0;
        resp_matmul_valid     = 1'b0;
        weights_req_valid     = 1'b0;
        activations_req_valid = 1'b0;
        vec_out_req_valid     = 1'b0;
        sa_start_valid        = 1'b0;
        busy                  = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_matmul_ready = 1'b1;
                busy             = 1'b0;
                if (cmd_matmul_valid) w_next = w_cmd_empty ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                weights_req_valid     = !r_w_sent;
                activations_req_valid = !r_a_sent;
                vec_out_req_valid     = !r_o_sent;
                if (w_all_sent) w_next = S_START;
            end
            S_START: begin
                sa_start_valid = 1'b1;
                if (sa_start_ready) w_next = S_WAIT;
            end
            S_WAIT:  if (w_tile_done) w_next = S_NEXT;
            S_NEXT:  w_next = (w_last_col && w_last_row) ? S_RESP : S_ISSUE;
            S_RESP: begin
                resp_matmul_valid = 1'b1;
                if (resp_matmul_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_m          <= '0;
            r_n          <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_act_cur    <= '0;
            r_wgt_cur    <= '0;
            r_out_cur    <= '0;
            r_wgt_base   <= '0;
            r_tiles_done <= '0;
            r_w_sent     <= 1'b0;
            r_a_sent     <= 1'b0;
            r_o_sent     <= 1'b0;
            r_seen_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (cmd_matmul_valid) begin
                    r_k          <= cmd_matmul_inner_dimension;
                    r_m          <= cmd_matmul_m_tiles;
                    r_n          <= cmd_matmul_n_tiles;
                    r_act_cur    <= cmd_matmul_act_addr;
                    r_wgt_cur    <= cmd_matmul_wgt_addr;
                    r_wgt_base   <= cmd_matmul_wgt_addr;
                    r_out_cur    <= cmd_matmul_out_addr;
                    r_i          <= '0;
                    r_j          <= '0;
                    r_tiles_done <= '0;
                    r_w_sent     <= 1'b0;
                    r_a_sent     <= 1'b0;
                    r_o_sent     <= 1'b0;
                end
                S_ISSUE: begin
                    r_w_sent <= r_w_sent || w_w_fire;
                    r_a_sent <= r_a_sent || w_a_fire;
                    r_o_sent <= r_o_sent || w_o_fire;
                end
                S_START: if (sa_start_ready) r_seen_busy <= 1'b0;
                S_WAIT:  if (!sa_start_ready) r_seen_busy <= 1'b1;
                S_NEXT: begin
                    // Addresses advance incrementally, so row-major order is what keeps them exact.
                    r_tiles_done <= r_tiles_done + 1'b1;
                    r_w_sent     <= 1'b0;
                    r_a_sent     <= 1'b0;
                    r_o_sent     <= 1'b0;
                    if (!w_last_col) begin
                        r_j       <= r_j + 1'b1;
                        r_wgt_cur <= r_wgt_cur + 64'(w_in_len);
                        r_out_cur <= r_out_cur + 64'(OUT_LEN);
                    end else if (!w_last_row) begin
                        r_j       <= '0;
                        r_i       <= r_i + 1'b1;
                        r_wgt_cur <= r_wgt_base;
                        r_act_cur <= r_act_cur + 64'(w_in_len);
                        r_out_cur <= r_out_cur + 64'(OUT_LEN);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
- Next-generation command controller for the systolic matmul accelerator.
- Where the previous core ran one DIM x DIM output tile per command, this block walks an M_TILES x N_TILES grid of output tiles per command. For each tile it issues activation, weight and output stream requests, starts the array, and waits for completion and write flush.
- It sits between the host command/response channels and the reader/writer stream units plus the SystolicArray control port.
- Array data paths are wired by the parent; this block drives only control and request channels.

Parameters:
- SYSTOLIC_ARRAY_DIM, 8, array edge length (elements per stream beat).
- DATA_WIDTH_BITS, 16, element width; must be a multiple of 8.
- TILE_CNT_BITS, 8, width of the m_tiles/n_tiles command fields.

Ports:
- clock  in  1  sole clock.
- areset  in  1  synchronous, active-high reset.
- cmd_matmul_valid/ready  in/out  1  command handshake.
- cmd_matmul_inner_dimension  in  20  K, the inner dimension in elements.
- cmd_matmul_m_tiles, cmd_matmul_n_tiles  in  TILE_CNT_BITS  tile grid size.
- cmd_matmul_out_addr, cmd_matmul_act_addr, cmd_matmul_wgt_addr  in  64  base byte addresses.
- resp_matmul_valid/ready  out/in  1  response handshake.
- resp_matmul_tiles_done  out  2*TILE_CNT_BITS  number of tiles computed.
- weights_req_valid/ready, activations_req_valid/ready, vec_out_req_valid/ready  out/in  1  per-stream request handshakes.
- weights_req_len, activations_req_len, vec_out_req_len  out  34  transfer length in bytes.
- weights_req_addr_address, activations_req_addr_address, vec_out_req_addr_address  out  64  transfer start address.
- weights_inProgress, activations_inProgress  in  1  reader still streaming.
- vec_out_isFlushed  in  1  writer has committed all data.
- sa_start_valid  out  1  start pulse request to the array.
- sa_start_ready  in  1  array idle / accepts start.
- sa_inner_dimension  out  20  K forwarded to the array.
- busy  out  1  state != IDLE.

Behaviour:
- Definitions:
  - B = DATA_WIDTH_BITS/8.
  - D = SYSTOLIC_ARRAY_DIM.
  - Command fields are latched on cmd fire; outputs derive only from latched copies.
- Lengths (34-bit, zero-extended, truncated on overflow):
  - act_len = wgt_len = K*D*B.
  - out_len = D*D*B.
- Addresses for tile (i,j), computed 64-bit modulo 2^64:
  - act = act_addr + i*act_len.
  - wgt = wgt_addr + j*wgt_len.
  - out = out_addr + (i*n_tiles + j)*out_len.
- Reset: state=IDLE, i=j=0, tiles_done=0. All *_valid outputs = 0, busy=0, cmd_matmul_ready=1 in the first cycle after reset.
- cmd_matmul_ready = (state==IDLE). resp_matmul_valid = (state==RESPONSE).
- IDLE:
  - On cmd fire, latch fields and clear i, j, tiles_done.
  - If K==0, m_tiles==0 or n_tiles==0, go to RESPONSE; no requests are issued and tiles_done=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - All three req_valid assert in the first ISSUE cycle.
  - Each valid is held with stable len/addr until its own handshake, then drops; per-stream "sent" flags track this.
  - Handshakes may complete in any order or in the same cycle.
  - When all three are sent, go to START.
- START:
  - sa_start_valid=1 and sa_inner_dimension=K until sa_start_ready.
  - On that fire go to WAIT and clear seen_busy.
- WAIT:
  - seen_busy sets when sa_start_ready==0.
  - Exit when seen_busy (or sa_start_ready low this cycle is not sufficient) && sa_start_ready && vec_out_isFlushed && !weights_inProgress && !activations_inProgress; then go to NEXT.
- NEXT (1 cycle):
  - tiles_done++.
  - If j+1<n_tiles: j++.
  - Else if i+1<m_tiles: j=0, i++.
  - Otherwise go to RESPONSE. Non-final tiles go to ISSUE.
  - Iteration order is row-major: j is the inner loop.
- RESPONSE: resp_matmul_valid=1 and tiles_done is stable; on handshake go to IDLE.
- Backpressure: a command presented while busy is not accepted; cmd_matmul_ready stays 0.
- areset asserted in any state: next cycle matches the reset values. In-flight requests are abandoned with no response.

Test Plan:
- D=8, 16-bit, K=4, 1x1 grid, act=0x1000, wgt=0x2000, out=0x3000.
  - Requests: len 64/64/128 at those addresses.
  - One sa_start fire; response with tiles_done=1.
- 2x3 grid, K=8 (len 128), same bases.
  - Six tiles in order (0,0),(0,1),(0,2),(1,0)…
  - Tile (1,2): act=0x1080, wgt=0x2100, out=0x3000+5*128=0x3280.
  - tiles_done=6.
- m_tiles=0 (also K=0).
  - Response within 2 cycles of fire, tiles_done=0.
  - No req_valid or sa_start_valid ever high.
- Reader-ready backpressure:
  - weights_req_ready held low 10 cycles while others accept immediately.
  - weights_req_valid/addr/len stay stable.
  - sa_start_valid rises only the cycle after the weight handshake.
- Completion gating: in WAIT, hold vec_out_isFlushed=0 for 20 cycles after the array goes idle → no NEXT. Flush rises → next tile issues 2 cycles later.
- Reset mid-operation: assert areset during WAIT of tile 3 of 6.
  - All valids 0 and busy=0 next cycle.
  - A new 1x1 command then completes normally with tiles_done=1.
